weight_select_multi: RTL and testbench

- Parametrised successor to the single-channel weight cycler.
- Holds N_CH independent weight registers, each stepped up or down by its own inc/dec buttons.
- Features: rising-edge press detection, selectable wrap or saturate at range ends, optional hold-to-auto-repeat.
- Sits between the debounced front-panel buttons and the harmonic/voice mixer, which consumes the packed weights bus.

---
 rtl/weight_select_multi.sv | 119 +++++++++++
 tb/tb_weight_select_multi.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_select_multi.sv
// N_CH independent weight registers stepped by rising edges of per-channel inc/dec buttons,
// with wrap or saturate at the range ends and optional hold-to-auto-repeat.
module weight_select_multi #(
  parameter int N_CH          = 3,
  parameter int LEVELS        = 3,
  parameter int W             = 2,
  parameter int RESET_LEVEL   = 0,
  parameter int WRAP          = 1,
  parameter int HOLD_CYCLES   = 0,
  parameter int REPEAT_CYCLES = 8,
  parameter int CW            = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_CH-1:0]   inc_button,
  input  logic [N_CH-1:0]   dec_button,
  output logic [N_CH*W-1:0] weights,
  output logic [N_CH-1:0]   step_pulse
);

  typedef enum logic {HOLD_WAIT, REPEAT} hold_state_t;

  localparam logic [W-1:0]  TOP    = W'(LEVELS - 1);
  localparam logic [W-1:0]  RST_W  = W'(RESET_LEVEL);
  localparam logic [CW-1:0] HOLD_N = CW'(HOLD_CYCLES);
  localparam logic [CW-1:0] REP_N  = CW'(REPEAT_CYCLES);
  localparam bit            REP_EN = (HOLD_CYCLES > 0);

  logic [N_CH-1:0][W-1:0]  w_q, w_d;
  logic [N_CH-1:0][CW-1:0] cnt_q, cnt_d;
  logic [N_CH-1:0]         inc_prev_q, dec_prev_q;
  logic [N_CH-1:0]         dir_q, dir_d;
  logic [N_CH-1:0]         pulse_d;
  logic [N_CH-1:0]         inc_rise, dec_rise, single;
  logic [N_CH-1:0]         up_req, dn_req;
  hold_state_t             st_q [N_CH];
  hold_state_t             st_d [N_CH];

  assign inc_rise = inc_button & ~inc_prev_q;
  assign dec_rise = dec_button & ~dec_prev_q;
  assign single   = inc_button ^ dec_button;
  assign weights  = w_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      w_q        <= {N_CH{RST_W}};
      step_pulse <= '0;
      cnt_q      <= '0;
      dir_q      <= '0;
      inc_prev_q <= inc_button;
      dec_prev_q <= dec_button;
      for (int unsigned i = 0; i < N_CH; i++) st_q[i] <= HOLD_WAIT;
    end else begin
      w_q        <= w_d;
      step_pulse <= pulse_d;
      cnt_q      <= cnt_d;
      dir_q      <= dir_d;
      inc_prev_q <= inc_button;
      dec_prev_q <= dec_button;
      for (int unsigned i = 0; i < N_CH; i++) st_q[i] <= st_d[i];
    end
  end

  always_comb begin
    w_d     = w_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    pulse_d = '0;
    up_req  = '0;
    dn_req  = '0;
    for (int unsigned i = 0; i < N_CH; i++) st_d[i] = st_q[i];

    for (int unsigned i = 0; i < N_CH; i++) begin
      up_req[i] = inc_rise[i] & ~dec_rise[i];
      dn_req[i] = dec_rise[i] & ~inc_rise[i];

      if (REP_EN) begin
        // A zero count marks an idle channel: holds only continue from a single-button press.
        if (single[i] && (inc_rise[i] || dec_rise[i])) begin
          cnt_d[i] = CW'(1);
          st_d[i]  = HOLD_WAIT;
          dir_d[i] = inc_button[i];
        end else if (single[i] && (cnt_q[i] != '0) && (dir_q[i] == inc_button[i])) begin
          if ((st_q[i] == HOLD_WAIT && cnt_q[i] == HOLD_N) ||
              (st_q[i] == REPEAT    && cnt_q[i] == REP_N)) begin
            up_req[i] = dir_q[i];
            dn_req[i] = ~dir_q[i];
            cnt_d[i]  = CW'(1);
            st_d[i]   = REPEAT;
          end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
          end
        end else begin
          cnt_d[i] = '0;
          st_d[i]  = HOLD_WAIT;
        end
      end

      if (up_req[i]) begin
        if (w_q[i] != TOP) begin
          w_d[i]     = w_q[i] + W'(1);
          pulse_d[i] = 1'b1;
        end else if (WRAP != 0) begin
          w_d[i]     = '0;
          pulse_d[i] = 1'b1;
        end
      end else if (dn_req[i]) begin
        if (w_q[i] != '0) begin
          w_d[i]     = w_q[i] - W'(1);
          pulse_d[i] = 1'b1;
        end else if (WRAP != 0) begin
          w_d[i]     = TOP;
          pulse_d[i] = 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_weight_select_multi.sv
// Bench for weight_select_multi: three configurations driven by a vector table, hand sequences
// and random button activity compared against an age-based behavioural model.
module tb_weight_select_multi;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [2:0] inc_v [3];
  logic [2:0] dec_v [3];
  logic [5:0] wa, wb;
  logic [8:0] wc;
  logic [2:0] pa, pb, pc;

  weight_select_multi #(.N_CH(3), .LEVELS(3), .W(2), .RESET_LEVEL(0), .WRAP(1),
                        .HOLD_CYCLES(0), .REPEAT_CYCLES(8), .CW(16)) dut_a (
    .clk(clk), .reset(reset), .inc_button(inc_v[0]), .dec_button(dec_v[0]),
    .weights(wa), .step_pulse(pa));

  weight_select_multi #(.N_CH(3), .LEVELS(3), .W(2), .RESET_LEVEL(0), .WRAP(0),
                        .HOLD_CYCLES(3), .REPEAT_CYCLES(2), .CW(16)) dut_b (
    .clk(clk), .reset(reset), .inc_button(inc_v[1]), .dec_button(dec_v[1]),
    .weights(wb), .step_pulse(pb));

  weight_select_multi #(.N_CH(3), .LEVELS(8), .W(3), .RESET_LEVEL(0), .WRAP(1),
                        .HOLD_CYCLES(4), .REPEAT_CYCLES(2), .CW(16)) dut_c (
    .clk(clk), .reset(reset), .inc_button(inc_v[2]), .dec_button(dec_v[2]),
    .weights(wc), .step_pulse(pc));

  int total = 0;
  int bad   = 0;
  bit use_model = 1'b0;

  // Model configuration per instance
  int lv [3] = '{3, 3, 8};
  int wr [3] = '{1, 0, 1};
  int hd [3] = '{0, 3, 4};
  int rp [3] = '{8, 2, 2};
  int wbits [3] = '{2, 2, 3};

  // Model state: value, age of current hold (-1 = none), hold direction
  int m_val [3][3];
  int m_age [3][3];
  int m_dir [3][3];
  bit m_pi  [3][3];
  bit m_pd  [3][3];
  bit m_pu  [3][3];

  typedef struct {
    logic [2:0] inc;
    logic [2:0] dec;
    logic [5:0] w;
    logic [2:0] p;
  } vec_t;
  vec_t tab [16];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit bi, bd, ir, dr;
    int dir, nv;
    for (int k = 0; k < 3; k++) begin
      for (int ch = 0; ch < 3; ch++) begin
        bi = inc_v[k][ch];
        bd = dec_v[k][ch];
        if (!reset) begin
          m_val[k][ch] = 0;
          m_age[k][ch] = -1;
          m_pu[k][ch]  = 1'b0;
        end else begin
          ir  = bi && !m_pi[k][ch];
          dr  = bd && !m_pd[k][ch];
          dir = 0;
          if (ir && !dr) dir = 1;
          else if (dr && !ir) dir = -1;
          if (hd[k] > 0) begin
            if (bi != bd && (ir || dr)) begin
              m_age[k][ch] = 0;
              m_dir[k][ch] = bi ? 1 : -1;
            end else if (bi != bd && m_age[k][ch] >= 0 && m_dir[k][ch] == (bi ? 1 : -1)) begin
              m_age[k][ch]++;
              if (m_age[k][ch] == hd[k] ||
                  (m_age[k][ch] > hd[k] && (m_age[k][ch] - hd[k]) % rp[k] == 0))
                dir = m_dir[k][ch];
            end else begin
              m_age[k][ch] = -1;
            end
          end
          nv = m_val[k][ch] + dir;
          if (nv < 0) nv = (wr[k] != 0) ? lv[k] - 1 : 0;
          if (nv >= lv[k]) nv = (wr[k] != 0) ? 0 : lv[k] - 1;
          m_pu[k][ch]  = (nv != m_val[k][ch]);
          m_val[k][ch] = nv;
        end
        m_pi[k][ch] = bi;
        m_pd[k][ch] = bd;
      end
    end
  endtask

  task automatic compare_model();
    int ew, ep;
    logic [31:0] aw, ap;
    for (int k = 0; k < 3; k++) begin
      ew = 0;
      ep = 0;
      for (int ch = 0; ch < 3; ch++) begin
        ew |= m_val[k][ch] << (ch * wbits[k]);
        if (m_pu[k][ch]) ep |= (1 << ch);
      end
      aw = (k == 0) ? 32'(wa) : (k == 1) ? 32'(wb) : 32'(wc);
      ap = (k == 0) ? 32'(pa) : (k == 1) ? 32'(pb) : 32'(pc);
      check($sformatf("model weights inst%0d", k), aw, ew);
      check($sformatf("model pulse inst%0d", k), ap, ep);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    if (use_model) compare_model();
  endtask

  task automatic idle_all();
    for (int k = 0; k < 3; k++) begin
      inc_v[k] = '0;
      dec_v[k] = '0;
    end
  endtask

  initial begin
    int npulse, steps;
    bit exp_p;

    tab[0]  = '{3'b001, 3'b000, 6'h01, 3'b001};
    tab[1]  = '{3'b000, 3'b000, 6'h01, 3'b000};
    tab[2]  = '{3'b001, 3'b000, 6'h02, 3'b001};
    tab[3]  = '{3'b000, 3'b000, 6'h02, 3'b000};
    tab[4]  = '{3'b001, 3'b000, 6'h00, 3'b001};
    tab[5]  = '{3'b000, 3'b000, 6'h00, 3'b000};
    tab[6]  = '{3'b001, 3'b000, 6'h01, 3'b001};
    tab[7]  = '{3'b000, 3'b000, 6'h01, 3'b000};
    tab[8]  = '{3'b011, 3'b001, 6'h05, 3'b010};
    tab[9]  = '{3'b000, 3'b000, 6'h05, 3'b000};
    tab[10] = '{3'b000, 3'b100, 6'h25, 3'b100};
    tab[11] = '{3'b000, 3'b000, 6'h25, 3'b000};
    tab[12] = '{3'b010, 3'b000, 6'h29, 3'b010};
    tab[13] = '{3'b010, 3'b010, 6'h25, 3'b010};
    tab[14] = '{3'b010, 3'b000, 6'h25, 3'b000};
    tab[15] = '{3'b000, 3'b000, 6'h25, 3'b000};

    reset = 1'b0;
    idle_all();
    repeat (3) tick();
    check("reset weights a", 32'(wa), 32'h0);
    check("reset weights b", 32'(wb), 32'h0);
    check("reset weights c", 32'(wc), 32'h0);
    check("reset pulses", 32'({pa, pb, pc}), 32'h0);
    reset = 1'b1;
    tick();

    for (int r = 0; r < 16; r++) begin
      inc_v[0] = tab[r].inc;
      dec_v[0] = tab[r].dec;
      tick();
      check($sformatf("table weights row%0d", r), 32'(wa), 32'(tab[r].w));
      check($sformatf("table pulse row%0d", r), 32'(pa), 32'(tab[r].p));
    end

    // Hold inc[1] with auto-repeat disabled: a single step only
    npulse = 0;
    inc_v[0] = 3'b010;
    repeat (20) begin
      tick();
      npulse += int'(pa[1]);
    end
    check("no-repeat hold pulses", 32'(npulse), 32'd1);
    check("no-repeat hold weight", 32'(wa[3:2]), 32'd2);
    idle_all();
    tick();

    // Saturation on instance b, channel 2
    dec_v[1] = 3'b100;
    tick();
    check("sat dec weight", 32'(wb[5:4]), 32'd0);
    check("sat dec pulse", 32'(pb), 32'd0);
    idle_all();
    tick();
    for (int n = 0; n < 3; n++) begin
      inc_v[1] = 3'b100;
      tick();
      check($sformatf("sat inc weight %0d", n), 32'(wb[5:4]), (n == 0) ? 32'd1 : 32'd2);
      check($sformatf("sat inc pulse %0d", n), 32'(pb), (n < 2) ? 32'b100 : 32'b000);
      idle_all();
      tick();
    end

    // Auto-repeat on instance c: steps at press age 0, 4, 6, 8
    steps = 0;
    inc_v[2] = 3'b001;
    for (int k = 0; k < 9; k++) begin
      tick();
      exp_p = (k == 0 || k == 4 || k == 6 || k == 8);
      if (exp_p) steps++;
      check($sformatf("repeat pulse t%0d", k), 32'(pc), exp_p ? 32'b001 : 32'b000);
      check($sformatf("repeat weight t%0d", k), 32'(wc[2:0]), 32'(steps));
    end
    idle_all();
    tick();
    check("repeat release weight", 32'(wc[2:0]), 32'd4);
    check("repeat release pulse", 32'(pc), 32'd0);

    // Reset in the middle of a hold
    inc_v[2] = 3'b001;
    tick();
    check("pre-reset press weight", 32'(wc[2:0]), 32'd5);
    reset = 1'b0;
    repeat (2) tick();
    check("mid-hold reset weight", 32'(wc), 32'd0);
    check("mid-hold reset pulse", 32'(pc), 32'd0);
    reset = 1'b1;
    npulse = 0;
    repeat (8) begin
      tick();
      npulse += int'(pc[0]);
    end
    check("held through reset pulses", 32'(npulse), 32'd0);
    check("held through reset weight", 32'(wc[2:0]), 32'd0);
    idle_all();
    tick();
    inc_v[2] = 3'b001;
    tick();
    check("re-press weight", 32'(wc[2:0]), 32'd1);
    check("re-press pulse", 32'(pc), 32'b001);
    idle_all();
    tick();

    // Random button activity against the model
    use_model = 1'b1;
    reset = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    for (int n = 0; n < 800; n++) begin
      for (int k = 0; k < 3; k++) begin
        for (int ch = 0; ch < 3; ch++) begin
          if ($urandom_range(0, 5) == 0) inc_v[k][ch] = ~inc_v[k][ch];
          if ($urandom_range(0, 7) == 0) dec_v[k][ch] = ~dec_v[k][ch];
        end
      end
      reset = ($urandom_range(0, 149) != 0);
      tick();
    end
    reset = 1'b1;
    idle_all();
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
